// File: rtl/spi_flash_resp_pkg.sv
// Shared constants and FSM state type for the SPI NOR flash responder.
package spi_flash_resp_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_DUAL_READ = 8'h3B;

    localparam int SPI_ADDR_BITS = 24;
    localparam int DUMMY_CYCLES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } flash_state_e;

endpackage

// File: rtl/spi_flash_resp_pin_sync.sv
// Synchronizes csb/sck/io0 into clk_i and derives edge strobes from the last two stages.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic csb_i,
    input  logic sck_i,
    input  logic io0_i,
    output logic io0_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic csb_fall_o,
    output logic csb_rise_o
);

    logic [SYNC_STAGES-1:0] csb_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] io0_q;

    // csb resets to 0 so a select already held low across reset never looks like a fresh fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csb_q <= '0;
            sck_q <= '0;
            io0_q <= '0;
        end else begin
            csb_q <= {csb_q[SYNC_STAGES-2:0], csb_i};
            sck_q <= {sck_q[SYNC_STAGES-2:0], sck_i};
            io0_q <= {io0_q[SYNC_STAGES-2:0], io0_i};
        end
    end

    assign io0_o      = io0_q[SYNC_STAGES-1];
    assign sck_rise_o =  sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
    assign sck_fall_o = ~sck_q[SYNC_STAGES-2] &  sck_q[SYNC_STAGES-1];
    assign csb_fall_o = ~csb_q[SYNC_STAGES-2] &  csb_q[SYNC_STAGES-1];
    assign csb_rise_o =  csb_q[SYNC_STAGES-2] & ~csb_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_resp.sv
// SPI NOR flash responder serving 0x03/0x0B reads from a byte-wide synchronous memory.
// Define SPI_FLASH_RESP_DUAL_EN to add 0x3B dual-output read on io1/io0.
module spi_flash_resp
    import spi_flash_resp_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              spi_csb_i,
    input  logic              spi_clk_i,
    input  logic              spi_io0_i,
    output logic              spi_io0_o,
    output logic              spi_io0_oe_o,
    output logic              spi_io1_o,
    output logic              spi_io1_oe_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              cmd_err_o,
    output logic [2:0]        dbg_state_o
);

    logic io0_s, sck_rise, sck_fall, csb_fall, csb_rise;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .csb_i      (spi_csb_i),
        .sck_i      (spi_clk_i),
        .io0_i      (spi_io0_i),
        .io0_o      (io0_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .csb_fall_o (csb_fall),
        .csb_rise_o (csb_rise)
    );

    flash_state_e      state, state_n;
    logic [4:0]        cnt;
    logic [6:0]        op_sr;
    logic [7:0]        op_next;
    logic [ADDR_W-1:0] addr_sr, addr_q;
    logic [7:0]        sr;
    logic              with_dummy, dual_mode;
    logic              rd_q, load_q, io1_q, io1_oe_q, cmd_err_q;
    logic              first_rd, next_rd, cmd_err_n, op_ok;
    logic [4:0]        byte_last;

    assign op_next   = {op_sr, io0_s};
    assign byte_last = dual_mode ? 5'd3 : 5'd7;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        first_rd  = 1'b0;
        next_rd   = 1'b0;
        cmd_err_n = 1'b0;
        op_ok     = (op_next == CMD_READ) || (op_next == CMD_FAST_READ);
`ifdef SPI_FLASH_RESP_DUAL_EN
        if (op_next == CMD_DUAL_READ) op_ok = 1'b1;
`endif
        if (state != ST_IDLE && csb_rise) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (csb_fall) state_n = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && cnt == 5'd7) begin
                        if (op_ok) begin
                            state_n = ST_ADDR;
                        end else begin
                            state_n   = ST_IGNORE;
                            cmd_err_n = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && cnt == 5'(SPI_ADDR_BITS - 1)) begin
                        first_rd = 1'b1;
                        state_n  = with_dummy ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: if (sck_rise && cnt == 5'(DUMMY_CYCLES - 1)) state_n = ST_DATA;
                ST_DATA:  if (sck_rise && cnt == byte_last) next_rd = 1'b1;
                default: ;
            endcase
        end
    end

    // Memory port: mem_rd_o/mem_addr_o are valid together for one cycle; data is taken the cycle after.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt        <= '0;
            op_sr      <= '0;
            with_dummy <= 1'b0;
            addr_sr    <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            load_q     <= 1'b0;
            sr         <= '0;
            io1_q      <= 1'b0;
            io1_oe_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            rd_q      <= first_rd | next_rd;
            load_q    <= rd_q;
            cmd_err_q <= cmd_err_n;

            if (state_n != state || next_rd) cnt <= '0;
            else if (sck_rise)               cnt <= cnt + 5'd1;

            if (state == ST_CMD && sck_rise) op_sr <= op_next[6:0];
            if (state == ST_CMD && state_n == ST_ADDR) with_dummy <= (op_next != CMD_READ);

            // Only the low ADDR_W address bits survive the 24-bit shift.
            if (state == ST_ADDR && sck_rise) addr_sr <= {addr_sr[ADDR_W-2:0], io0_s};
            if (first_rd)     addr_q <= {addr_sr[ADDR_W-2:0], io0_s};
            else if (next_rd) addr_q <= addr_q + ADDR_W'(1);

            if (load_q)
                sr <= mem_rdata_i;
            else if (state == ST_DATA && sck_fall)
                sr <= dual_mode ? {sr[5:0], 2'b00} : {sr[6:0], 1'b0};

            if (state != ST_DATA || state_n != ST_DATA) begin
                io1_q    <= 1'b0;
                io1_oe_q <= 1'b0;
            end else if (sck_fall) begin
                io1_q    <= sr[7];
                io1_oe_q <= 1'b1;
            end
        end
    end

`ifdef SPI_FLASH_RESP_DUAL_EN
    logic io0_q, io0_oe_q, dual_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dual_q   <= 1'b0;
            io0_q    <= 1'b0;
            io0_oe_q <= 1'b0;
        end else begin
            if (state == ST_CMD && state_n == ST_ADDR) dual_q <= (op_next == CMD_DUAL_READ);
            if (!dual_q || state != ST_DATA || state_n != ST_DATA) begin
                io0_q    <= 1'b0;
                io0_oe_q <= 1'b0;
            end else if (sck_fall) begin
                io0_q    <= sr[6];
                io0_oe_q <= 1'b1;
            end
        end
    end

    assign dual_mode    = dual_q;
    assign spi_io0_o    = io0_q;
    assign spi_io0_oe_o = io0_oe_q;
`else
    assign dual_mode    = 1'b0;
    assign spi_io0_o    = 1'b0;
    assign spi_io0_oe_o = 1'b0;
`endif

    assign spi_io1_o    = io1_q;
    assign spi_io1_oe_o = io1_oe_q;
    assign mem_rd_o     = rd_q;
    assign mem_addr_o   = addr_q;
    assign cmd_err_o    = cmd_err_q;
    assign busy_o       = (state != ST_IDLE);
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: SPI host driver, BRAM model and byte-level read scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_resp;

    localparam int ADDR_W   = 16;
    localparam int CLK_HALF = 5;
    localparam int SCK_HALF = 60;   // SCK period = 12 clk_i periods

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              spi_csb_i = 1'b1;
    logic              spi_clk_i = 1'b0;
    logic              spi_io0_i = 1'b0;
    logic              spi_io0_o, spi_io0_oe_o, spi_io1_o, spi_io1_oe_o;
    logic              mem_rd_o, busy_o, cmd_err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_rdata_i = 8'h00;
    logic [2:0]        dbg_state_o;

    logic [7:0] mem [0:65535];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int rd_total = 0;
    int err_total = 0;
    int oe_total = 0;
    int oe_gaps = 0;
    int rd_before_last = 0;

    always #CLK_HALF clk_i = ~clk_i;

    spi_flash_resp #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .spi_csb_i    (spi_csb_i),
        .spi_clk_i    (spi_clk_i),
        .spi_io0_i    (spi_io0_i),
        .spi_io0_o    (spi_io0_o),
        .spi_io0_oe_o (spi_io0_oe_o),
        .spi_io1_o    (spi_io1_o),
        .spi_io1_oe_o (spi_io1_oe_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .cmd_err_o    (cmd_err_o),
        .dbg_state_o  (dbg_state_o)
    );

    always @(posedge clk_i) if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];

    always @(negedge clk_i) begin
        if (mem_rd_o) rd_total <= rd_total + 1;
        if (cmd_err_o) err_total <= err_total + 1;
        if (spi_io1_oe_o || spi_io0_oe_o) oe_total <= oe_total + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic spi_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_io0_i = val[i];
            #SCK_HALF spi_clk_i = 1'b1;
            #SCK_HALF spi_clk_i = 1'b0;
        end
    endtask

    task automatic spi_begin();
        spi_csb_i = 1'b0;
        #SCK_HALF;
    endtask

    task automatic spi_finish();
        #SCK_HALF;
        spi_csb_i = 1'b1;
        spi_io0_i = 1'b0;
        #(4 * SCK_HALF);
    endtask

    // Host samples just before each rise; bytes land in got_q.
    task automatic spi_read(input int n, input bit dual);
        logic [7:0] b;
        int nb;
        nb = dual ? 4 : 8;
        for (int k = 0; k < n; k++) begin
            b = 8'h00;
            for (int j = 0; j < nb; j++) begin
                #SCK_HALF;
                if (k == n - 1 && j == nb - 1) rd_before_last = rd_total;
                if (!spi_io1_oe_o || (dual && !spi_io0_oe_o)) oe_gaps++;
                b = dual ? {b[5:0], spi_io1_o, spi_io0_o} : {b[6:0], spi_io1_o};
                spi_clk_i = 1'b1;
                #SCK_HALF spi_clk_i = 1'b0;
            end
            got_q.push_back(b);
        end
    endtask

    // Reference model: byte i of a read at addr is mem[(addr + i) mod 2^16].
    task automatic model_expect(input logic [23:0] addr, input int n);
        logic [15:0] ea;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            ea = addr[15:0] + 16'(i);
            exp_q.push_back(mem[ea]);
        end
    endtask

    task automatic run_read(input logic [7:0] op, input logic [23:0] addr, input int n);
        got_q.delete();
        oe_gaps = 0;
        model_expect(addr, n);
        spi_begin();
        spi_bits({24'h0, op}, 8);
        spi_bits({8'h0, addr}, 24);
        if (op != 8'h03) spi_bits(32'h0, 8);
        spi_read(n, op == 8'h3B);
        spi_finish();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({spi_io0_o, spi_io0_oe_o, spi_io1_o, spi_io1_oe_o, mem_rd_o, cmd_err_o, busy_o} !== 7'b0)
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {spi_io0_o, spi_io0_oe_o, spi_io1_o, spi_io1_oe_o, mem_rd_o, cmd_err_o, busy_o});
        else passed++;
        checks++;
        if (mem_addr_o !== 16'h0) $display("FAIL reset_addr got=%h exp=0000", mem_addr_o);
        else passed++;
        checks++;
        if (dbg_state_o !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state_o);
        else passed++;
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_basic();
        int r0;
        logic [7:0] e;
        for (int i = 16; i < 20; i++) mem[i] = 8'(i);
        r0 = rd_total;
        run_read(8'h03, 24'h000010, 4);
        for (int i = 0; i < 4; i++) begin
            e = 8'(16 + i);
            checks++;
            if (got_q[i] !== e) $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
        checks++;
        if (rd_before_last - r0 !== 4) $display("FAIL basic_rd_count got=%0d exp=4", rd_before_last - r0);
        else passed++;
        // The final bit-0 rise still prefetches the following byte.
        checks++;
        if (rd_total - r0 !== 5) $display("FAIL basic_rd_total got=%0d exp=5", rd_total - r0);
        else passed++;
        checks++;
        if (oe_gaps !== 0) $display("FAIL basic_oe got=%0d gaps exp=0", oe_gaps);
        else passed++;
    endtask

    task automatic test_fast_read();
        logic [7:0] e;
        got_q.delete();
        oe_gaps = 0;
        model_expect(24'h000100, 2);
        spi_begin();
        spi_bits(32'h0B, 8);
        spi_bits(32'h000100, 24);
        spi_bits(32'h0, 7);
        spi_io0_i = 1'b0;
        #SCK_HALF spi_clk_i = 1'b1;
        #SCK_HALF;
        checks++;
        if (spi_io1_oe_o !== 1'b0) $display("FAIL fast_oe_early got=%b exp=0", spi_io1_oe_o);
        else passed++;
        checks++;
        if (busy_o !== 1'b1) $display("FAIL fast_busy got=%b exp=1", busy_o);
        else passed++;
        spi_clk_i = 1'b0;
        spi_read(2, 1'b0);
        spi_finish();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) $display("FAIL fast_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        run_read(8'h03, {8'($urandom), 16'hFFFF}, 2);
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? mem[16'hFFFF] : mem[16'h0000];
            checks++;
            if (got_q[i] !== e) $display("FAIL wrap_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
    endtask

    task automatic test_unknown(input logic [7:0] op);
        int e0, o0, r0;
        logic [7:0] e;
        logic [23:0] a;
        e0 = err_total; o0 = oe_total; r0 = rd_total;
        spi_begin();
        spi_bits({24'h0, op}, 8);
        spi_bits($urandom, 24);
        spi_read(2, 1'b0);
        spi_finish();
        checks++;
        if (err_total - e0 !== 1) $display("FAIL unk%h_err got=%0d exp=1", op, err_total - e0);
        else passed++;
        checks++;
        if (oe_total - o0 !== 0) $display("FAIL unk%h_oe got=%0d exp=0", op, oe_total - o0);
        else passed++;
        checks++;
        if (rd_total - r0 !== 0) $display("FAIL unk%h_rd got=%0d exp=0", op, rd_total - r0);
        else passed++;
        a = 24'($urandom);
        run_read(8'h03, a, 3);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) $display("FAIL unk_after_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
    endtask

    task automatic test_abort();
        int r0;
        r0 = rd_total;
        spi_begin();
        spi_bits(32'h03, 8);
        spi_bits($urandom, 24);
        for (int j = 0; j < 3; j++) begin
            #SCK_HALF spi_clk_i = 1'b1;
            #SCK_HALF spi_clk_i = 1'b0;
        end
        #SCK_HALF;
        checks++;
        if (spi_io1_oe_o !== 1'b1) $display("FAIL abort_oe_before got=%b exp=1", spi_io1_oe_o);
        else passed++;
        spi_csb_i = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++;
        if ({spi_io1_oe_o, spi_io0_oe_o, busy_o} !== 3'b000)
            $display("FAIL abort_oe_after got=%b exp=000", {spi_io1_oe_o, spi_io0_oe_o, busy_o});
        else passed++;
        #(4 * SCK_HALF);
        checks++;
        if (rd_total - r0 !== 1) $display("FAIL abort_rd got=%0d exp=1", rd_total - r0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int r0;
        logic [7:0] e;
        logic [23:0] a;
        a = 24'($urandom);
        spi_begin();
        spi_bits(32'h03, 8);
        spi_bits({20'h0, a[23:12]}, 12);
        rst_n_i = 1'b0;
        #(2 * 2 * CLK_HALF);
        checks++;
        if ({spi_io0_o, spi_io0_oe_o, spi_io1_o, spi_io1_oe_o, mem_rd_o, cmd_err_o, busy_o} !== 7'b0)
            $display("FAIL rstmid_outputs got=%b exp=0000000",
                     {spi_io0_o, spi_io0_oe_o, spi_io1_o, spi_io1_oe_o, mem_rd_o, cmd_err_o, busy_o});
        else passed++;
        checks++;
        if (mem_addr_o !== 16'h0) $display("FAIL rstmid_addr got=%h exp=0000", mem_addr_o);
        else passed++;
        rst_n_i = 1'b1;
        r0 = rd_total;
        // csb is still low: these clocks must not start a frame.
        spi_bits(32'h03, 8);
        spi_bits({8'h0, a}, 24);
        checks++;
        if (busy_o !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy_o);
        else passed++;
        checks++;
        if (rd_total - r0 !== 0) $display("FAIL rstmid_rd got=%0d exp=0", rd_total - r0);
        else passed++;
        spi_finish();
        run_read(8'h03, a, 2);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int r0, n;
        logic [7:0] op, e;
        logic [23:0] a;
        for (int f = 0; f < 6; f++) begin
            op = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B;
            a  = 24'($urandom);
            n  = $urandom_range(1, 3);
            r0 = rd_total;
            run_read(op, a, n);
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                checks++;
                if (got_q[i] !== e)
                    $display("FAIL b2b%0d_op%h_a%h_byte%0d got=%h exp=%h", f, op, a, i, got_q[i], e);
                else passed++;
            end
            checks++;
            if (rd_total - r0 !== n + 1) $display("FAIL b2b%0d_rd got=%0d exp=%0d", f, rd_total - r0, n + 1);
            else passed++;
            checks++;
            if (oe_gaps !== 0) $display("FAIL b2b%0d_oe got=%0d gaps exp=0", f, oe_gaps);
            else passed++;
        end
    endtask

`ifdef SPI_FLASH_RESP_DUAL_EN
    task automatic test_dual();
        int r0;
        logic [7:0] e;
        mem[16'h0020] = 8'hA5;
        r0 = rd_total;
        run_read(8'h3B, 24'h000020, 2);
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? 8'hA5 : mem[16'h0021];
            checks++;
            if (got_q[i] !== e) $display("FAIL dual_byte%0d got=%h exp=%h", i, got_q[i], e);
            else passed++;
        end
        checks++;
        if (oe_gaps !== 0) $display("FAIL dual_oe got=%0d gaps exp=0", oe_gaps);
        else passed++;
        checks++;
        if (rd_total - r0 !== 3) $display("FAIL dual_rd got=%0d exp=3", rd_total - r0);
        else passed++;
    endtask
`else
    task automatic test_dual();
        test_unknown(8'h3B);
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_fast_read();
        test_wrap();
        test_unknown(8'h9F);
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_dual();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_flash_resp.md
Name: spi_flash_resp

Overview:
- Synthesizable SPI NOR flash responder: the target end of the SoC's flash interface (csb/clk/io0/io1).
- Lets FPGA builds and testbenches boot the SoC from on-chip BRAM instead of an external flash part.
- Oversamples the SPI pins in the system clock domain, decodes read commands, and fetches bytes from a synchronous byte-wide memory port.
- Requirement: clk_i frequency >= 8x the SPI clock frequency.

Parameters:
- ADDR_W, 16: memory byte-address width. Only the low ADDR_W bits of the 24-bit SPI address are used.
- SYNC_STAGES, 2: synchronizer depth on csb, clk and io0. Legal values 2..3.

Ports:
- clk_i, in, 1: system clock.
- rst_n_i, in, 1: asynchronous active-low reset.
- spi_csb_i, in, 1: chip select, active low.
- spi_clk_i, in, 1: SPI clock, mode 0.
- spi_io0_i, in, 1: MOSI (command/address in).
- spi_io0_o, out, 1: io0 output data (dual mode only).
- spi_io0_oe_o, out, 1: io0 output enable.
- spi_io1_o, out, 1: MISO data.
- spi_io1_oe_o, out, 1: io1 output enable.
- mem_rd_o, out, 1: one-cycle read strobe.
- mem_addr_o, out, ADDR_W: read byte address.
- mem_rdata_i, in, 8: read data, valid the clk_i cycle after mem_rd_o.
- busy_o, out, 1: transaction in progress (synced csb low).
- cmd_err_o, out, 1: one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Input capture: csb, clk and io0 each pass through SYNC_STAGES flip-flops. Rise/fall strobes come from the last two stages of the SCK chain.
- Sampling: io0 is sampled on SCK rise. Data is shifted out on SCK fall, MSB first.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE -> CMD on synced csb falling.
- CMD: 8 rises. Opcode handling:
  - 0x03 -> ADDR, with no dummy clocks.
  - 0x0B -> ADDR, then DUMMY for 8 clocks.
  - Any other opcode -> IGNORE and pulse cmd_err_o.
- ADDR: 24 rises, MSB first. On the 24th rise, latch addr[ADDR_W-1:0] and assert mem_rd_o for one cycle.
  - 0x03 -> DATA.
  - 0x0B -> DUMMY; the mem_rd_o is still issued at the 24th address rise.
- Prefetch: mem_rdata_i is loaded into the shift register the cycle after mem_rd_o, before the next SCK fall.
- DATA:
  - spi_io1_oe_o=1 from the first SCK fall after ADDR/DUMMY completes.
  - On each fall, drive the next bit.
  - On the rise of bit 0 of each byte: increment the address modulo 2^ADDR_W and issue mem_rd_o. The new byte loads at the following fall.
  - Address wraps from 2^ADDR_W-1 to 0 with no gap.
- IGNORE: all outputs disabled until csb deasserts.
- csb deassertion: from any state, go to IDLE. OE drops within SYNC_STAGES+1 clk_i cycles. Partial bytes are discarded and no further mem_rd_o is issued.
- Back-to-back transactions: csb re-asserted after >= 2 SCK periods high must be decoded correctly.
- SCK edges while csb is high are ignored.
- Reset asserted mid-transaction: immediately return to IDLE with all OE = 0. Decoding restarts only on a fresh csb falling edge seen after reset release.
- spi_io0_oe_o is 0 in every state unless the dual feature is active.

Optional Feature:
- Macro SPI_FLASH_RESP_DUAL_EN enables opcode 0x3B (dual output read).
- With it:
  - 0x3B follows the ADDR -> DUMMY(8) path.
  - DATA phase drives 2 bits per SCK fall: io1=bit7, io0=bit6, then bits 5/4, 3/2, 1/0.
  - spi_io0_oe_o=1 only during that DATA phase.
  - The next-byte prefetch is issued on the rise of the bit-1/0 pair.
- Without it: 0x3B is treated as an unknown opcode (IGNORE, cmd_err_o pulse), and spi_io0_o/spi_io0_oe_o are tied to 0.

Decomposition:
- Shared package holds:
  - opcode constants CMD_READ=0x03, CMD_FAST_READ=0x0B, CMD_DUAL_READ=0x3B;
  - SPI_ADDR_BITS=24 and DUMMY_CYCLES=8;
  - the FSM state enum.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizers on the three inputs plus SCK rise/fall strobes and csb fall/rise strobes.

Test Plan:
- Basic read: memory holds ramp [i]=i; 0x03 at address 0x000010, read 4 bytes -> MISO returns 0x10,0x11,0x12,0x13 MSB-first; exactly 4 mem_rd_o pulses.
- Fast read: 0x0B at address 0x000100 with 8 dummy clocks -> the first data bit appears on the fall after dummy clock 8; byte 0 = mem[0x100].
- Address wrap: ADDR_W=16, 0x03 at 0x00FFFF, read 2 bytes -> mem[0xFFFF], then mem[0x0000].
- Unknown opcode 0x9F -> cmd_err_o pulses once, both OE stay 0 for the whole frame, and a following 0x03 frame reads correctly.
- Abort and reset: deassert csb after 3 data bits -> OE=0 within 4 cycles. Separately, assert rst_n_i mid-ADDR -> all outputs 0, and the next full frame returns the correct data.
- Dual read (SPI_FLASH_RESP_DUAL_EN): 0x3B at 0x20 with mem[0x20]=0xA5 -> io1/io0 pairs 1/0, 1/0, 0/1, 0/1.
